// File: rtl/uart_cmd_decode_if.sv
// Byte-stream and SDRAM command bus between uart_rx, uart_cmd_decode and the SDRAM top.
// master drives the received bytes; slave (the decoder) drives the FIFO push and trigger pulses.
interface uart_cmd_decode_if;
  logic       uart_flag;
  logic [7:0] uart_data;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_data;
  logic       wr_trig;
  logic       rd_trig;
  logic       cmd_err;
  logic       busy;

  modport master (
    output uart_flag,
    output uart_data,
    input  wfifo_wr_en,
    input  wfifo_data,
    input  wr_trig,
    input  rd_trig,
    input  cmd_err,
    input  busy
  );

  modport slave (
    input  uart_flag,
    input  uart_data,
    output wfifo_wr_en,
    output wfifo_data,
    output wr_trig,
    output rd_trig,
    output cmd_err,
    output busy
  );
endinterface

// File: rtl/uart_cmd_decode.sv
// Parses the uart_rx byte stream into SDRAM write-FIFO pushes and read/write trigger pulses.
// Optional CMD_TIMEOUT_EN: abort an open write frame after TIMEOUT_CYC idle cycles.
module uart_cmd_decode #(
  parameter int          WR_BYTES    = 4,
  parameter logic [7:0]  CMD_WR      = 8'h55,
  parameter logic [7:0]  CMD_RD      = 8'hAA,
  parameter int          TIMEOUT_CYC = 1120
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  uart_cmd_decode_if.slave cmd
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WR_DATA = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(WR_BYTES - 1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_reg[1];

  state_t     state_reg,       state_next;
  logic [7:0] byte_cnt_reg,    byte_cnt_next;
  logic       wr_pend_reg,     wr_pend_next;
  logic       wfifo_wr_en_reg, wfifo_wr_en_next;
  logic [7:0] wfifo_data_reg,  wfifo_data_next;
  logic       wr_trig_reg,     wr_trig_next;
  logic       rd_trig_reg,     rd_trig_next;
  logic       cmd_err_reg,     cmd_err_next;
  logic       busy_reg,        busy_next;

`ifdef CMD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic              timeout_hit;

  // Firing at TIMEOUT_CYC-2 lands the registered cmd_err exactly TIMEOUT_CYC
  // cycles after the cycle that carried the last accepted flag.
  assign timeout_hit = (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 2));
`endif

  always_ff @(posedge sclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= 8'd0;
      wr_pend_reg     <= 1'b0;
      wfifo_wr_en_reg <= 1'b0;
      wfifo_data_reg  <= 8'd0;
      wr_trig_reg     <= 1'b0;
      rd_trig_reg     <= 1'b0;
      cmd_err_reg     <= 1'b0;
      busy_reg        <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      idle_cnt_reg    <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      byte_cnt_reg    <= byte_cnt_next;
      wr_pend_reg     <= wr_pend_next;
      wfifo_wr_en_reg <= wfifo_wr_en_next;
      wfifo_data_reg  <= wfifo_data_next;
      wr_trig_reg     <= wr_trig_next;
      rd_trig_reg     <= rd_trig_next;
      cmd_err_reg     <= cmd_err_next;
      busy_reg        <= busy_next;
`ifdef CMD_TIMEOUT_EN
      idle_cnt_reg    <= idle_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next       = state_reg;
    byte_cnt_next    = byte_cnt_reg;
    wr_pend_next     = 1'b0;
    wfifo_wr_en_next = 1'b0;
    wfifo_data_next  = wfifo_data_reg;
    // The trigger trails the final push by one cycle so the FIFO is complete.
    wr_trig_next     = wr_pend_reg;
    rd_trig_next     = 1'b0;
    cmd_err_next     = 1'b0;
    busy_next        = busy_reg;
`ifdef CMD_TIMEOUT_EN
    idle_cnt_next    = idle_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (cmd.uart_flag) begin
          if (cmd.uart_data == CMD_WR) begin
            state_next    = WR_DATA;
            byte_cnt_next = 8'd0;
            busy_next     = 1'b1;
`ifdef CMD_TIMEOUT_EN
            idle_cnt_next = '0;
`endif
          end else if (cmd.uart_data == CMD_RD) begin
            rd_trig_next = 1'b1;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
      end

      WR_DATA: begin
        if (cmd.uart_flag) begin
          // Opcode values are plain payload inside a frame.
          wfifo_wr_en_next = 1'b1;
          wfifo_data_next  = cmd.uart_data;
          if (byte_cnt_reg != 8'hFF) begin
            byte_cnt_next = byte_cnt_reg + 8'd1;
          end
          if (byte_cnt_reg == LAST_IDX) begin
            state_next   = IDLE;
            busy_next    = 1'b0;
            wr_pend_next = 1'b1;
          end
`ifdef CMD_TIMEOUT_EN
          idle_cnt_next = '0;
        end else if (timeout_hit) begin
          state_next    = IDLE;
          busy_next     = 1'b0;
          cmd_err_next  = 1'b1;
          idle_cnt_next = '0;
        end else begin
          idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
`endif
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign cmd.wfifo_wr_en = wfifo_wr_en_reg;
  assign cmd.wfifo_data  = wfifo_data_reg;
  assign cmd.wr_trig     = wr_trig_reg;
  assign cmd.rd_trig     = rd_trig_reg;
  assign cmd.cmd_err     = cmd_err_reg;
  assign cmd.busy        = busy_reg;

endmodule
